// File: rtl/convolution_result_reader.sv
// Captures convolution results from the memZ write port, then streams them out over valid/ready.
// Optional running checksum of the drained words: define RESULT_CHECKSUM_EN.
module convolution_result_reader #(
  parameter int DATA_WIDTH_MEMZ = 16,
  parameter int ADDR_WIDTH_MEMZ = 6,
  parameter int SIZE_H          = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH_MEMZ-2:0] sizeY,
  input  logic                       busy,
  input  logic                       done,
  input  logic                       writeZ,
  input  logic [ADDR_WIDTH_MEMZ-1:0] memZ_addr,
  input  logic [DATA_WIDTH_MEMZ-1:0] dataZ,
  output logic [DATA_WIDTH_MEMZ-1:0] out_data,
  output logic [ADDR_WIDTH_MEMZ-1:0] out_index,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
`ifdef RESULT_CHECKSUM_EN
  output logic [15:0]                chk_sum,
`endif
  output logic                       reader_busy,
  output logic                       overrun_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  localparam int DEPTH = 2 ** ADDR_WIDTH_MEMZ;

  logic [1:0]                 state_q, state_d;
  logic [ADDR_WIDTH_MEMZ-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH_MEMZ-1:0] sizeZ_q, sizeZ_d;
  logic                       overrun_q, overrun_d;
  logic [DATA_WIDTH_MEMZ-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH_MEMZ-1:0] lastIdx;
  logic                       isLast;
  logic                       beatXfer;

  assign lastIdx  = sizeZ_q - ADDR_WIDTH_MEMZ'(1);
  assign isLast   = (rd_ptr_q == lastIdx);
  assign beatXfer = (state_q == DRAIN) && out_ready;

  // Outputs are forced to zero outside DRAIN so reset and idle look identical.
  assign out_valid   = (state_q == DRAIN);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_index   = out_valid ? rd_ptr_q : '0;
  assign out_last    = out_valid && isLast;
  assign reader_busy = (state_q != IDLE);
  assign overrun_err = overrun_q;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    sizeZ_d   = sizeZ_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (busy) begin
          state_d   = CAPTURE;
          sizeZ_d   = ADDR_WIDTH_MEMZ'(sizeY) + ADDR_WIDTH_MEMZ'(SIZE_H - 1);
          overrun_d = 1'b0;
        end else if (writeZ) begin
          overrun_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (done) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
        end
      end
      DRAIN: begin
        if (writeZ) overrun_d = 1'b1;
        if (beatXfer) begin
          if (isLast) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH_MEMZ'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      sizeZ_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      sizeZ_q   <= sizeZ_d;
      overrun_q <= overrun_d;
    end
  end

  // The result array is deliberately left out of reset; unwritten entries stream stale data.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == CAPTURE) && writeZ) mem_q[memZ_addr] <= dataZ;
  end

`ifdef RESULT_CHECKSUM_EN
  logic [15:0] chk_sum_q, chk_sum_d;

  always_comb begin
    chk_sum_d = chk_sum_q;
    if ((state_q == CAPTURE) && done) chk_sum_d = '0;
    else if (beatXfer)                chk_sum_d = chk_sum_q + 16'(out_data);
  end

  always_ff @(posedge clk) begin
    if (rst) chk_sum_q <= '0;
    else     chk_sum_q <= chk_sum_d;
  end

  assign chk_sum = chk_sum_q;
`endif

endmodule

// File: tb/tb_convolution_result_reader.sv
// Scoreboard bench for convolution_result_reader: captured words are queued and checked as they drain.
module tb_convolution_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  sizeY;
  logic        busy, done, writeZ;
  logic [5:0]  memZ_addr;
  logic [15:0] dataZ;
  logic [15:0] out_data;
  logic [5:0]  out_index;
  logic        out_valid, out_last, out_ready;
  logic        reader_busy, overrun_err;
`ifdef RESULT_CHECKSUM_EN
  logic [15:0] chk_sum;
`endif

  convolution_result_reader dut (
    .clk(clk), .rst(rst), .sizeY(sizeY), .busy(busy), .done(done),
    .writeZ(writeZ), .memZ_addr(memZ_addr), .dataZ(dataZ),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready),
`ifdef RESULT_CHECKSUM_EN
    .chk_sum(chk_sum),
`endif
    .reader_busy(reader_busy), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  index;
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t       expQ[$];
  logic [15:0] tbMem [64];
  logic [15:0] wdata [64];
  int          nCompared = 0;
  int          nMismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one capture run; the final write coincides with done.
  task automatic applyStimulus(input logic [4:0] sy, input int nWrites);
    int sz;
    sz = int'(sy) + 2;
    @(negedge clk);
    busy = 1'b1; sizeY = sy;
    @(negedge clk);
    checkOutput("captureBusy", 32'(reader_busy), 32'd1);
    checkOutput("overrunClear", 32'(overrun_err), 32'd0);
    for (int i = 0; i < nWrites; i++) begin
      writeZ = 1'b1; memZ_addr = 6'(i); dataZ = wdata[i];
      tbMem[i] = wdata[i];
      done = (i == nWrites - 1);
      @(negedge clk);
    end
    writeZ = 1'b0; done = 1'b0; busy = 1'b0;
    for (int i = 0; i < sz; i++) expQ.push_back('{index: 6'(i), data: tbMem[i], last: (i == sz - 1)});
  endtask

  // Drains beats; readyMode 0 = always ready, 1 = alternating. Stops after stopAfter transfers.
  task automatic drainFrame(input int readyMode, input int stopAfter, input bit injectOverrun, output int cycles);
    beat_t exp;
    beat_t held;
    bit    stalled = 1'b0;
    bit    rdy;
    int    xfers = 0;
    cycles = 0;
    while (xfers < stopAfter && cycles < 200) begin
      if (stalled && out_valid) begin
        checkOutput("stallData", 32'(out_data), 32'(held.data));
        checkOutput("stallIndex", 32'(out_index), 32'(held.index));
        checkOutput("stallLast", 32'(out_last), 32'(held.last));
      end
      rdy = (readyMode == 0) ? 1'b1 : ((cycles % 2) == 0);
      out_ready = rdy;
      writeZ = injectOverrun && (cycles == 0);
      busy   = injectOverrun && (cycles == 0);
      done   = injectOverrun && (cycles == 0);
      memZ_addr = 6'd2; dataZ = 16'hFFFF;
      stalled = 1'b0;
      if (out_valid && rdy) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBeat", 32'(out_index), 32'hFFFF_FFFF);
        end else begin
          exp = expQ.pop_front();
          checkOutput("beatData", 32'(out_data), 32'(exp.data));
          checkOutput("beatIndex", 32'(out_index), 32'(exp.index));
          checkOutput("beatLast", 32'(out_last), 32'(exp.last));
        end
        xfers++;
      end else if (out_valid) begin
        stalled = 1'b1;
        held = '{index: out_index, data: out_data, last: out_last};
      end
      cycles++;
      @(negedge clk);
    end
    writeZ = 1'b0; busy = 1'b0; done = 1'b0; out_ready = 1'b0;
    checkOutput("drainXfers", 32'(xfers), 32'(stopAfter));
  endtask

  int cyc;

  initial begin
    rst = 1'b1; sizeY = '0; busy = 0; done = 0; writeZ = 0; memZ_addr = '0; dataZ = '0; out_ready = 0;
    repeat (2) @(negedge clk);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstBusy", 32'(reader_busy), 32'd0);
    checkOutput("rstOverrun", 32'(overrun_err), 32'd0);
    checkOutput("rstLast", 32'(out_last), 32'd0);
    rst = 1'b0;

    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checkOutput("idleDoneIgnored", 32'(reader_busy), 32'd0);

    $display("[TB] frame with full throughput");
    for (int i = 0; i < 6; i++) wdata[i] = 16'((i + 1) * 10);
    applyStimulus(5'd4, 6);
    drainFrame(0, 6, 1'b0, cyc);
    checkOutput("throughputCycles", 32'(cyc), 32'd6);
    checkOutput("endValid", 32'(out_valid), 32'd0);
    checkOutput("endBusy", 32'(reader_busy), 32'd0);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("[TB] frame with backpressure");
    applyStimulus(5'd4, 6);
    drainFrame(1, 6, 1'b0, cyc);
    checkOutput("bpEndBusy", 32'(reader_busy), 32'd0);
    checkOutput("bpQueueEmpty", 32'(expQ.size()), 32'd0);

    $display("[TB] overrun during drain");
    applyStimulus(5'd4, 6);
    drainFrame(0, 6, 1'b1, cyc);
    checkOutput("overrunSet", 32'(overrun_err), 32'd1);
    checkOutput("ovEndBusy", 32'(reader_busy), 32'd0);
    checkOutput("ovQueueEmpty", 32'(expQ.size()), 32'd0);

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 6; i++) wdata[i] = 16'(16'h0100 + i);
    applyStimulus(5'd4, 6);
    drainFrame(0, 3, 1'b0, cyc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstValid", 32'(out_valid), 32'd0);
    checkOutput("midRstBusy", 32'(reader_busy), 32'd0);
    expQ.delete();
    wdata[0] = 16'hABCD; wdata[1] = 16'h1234;
    applyStimulus(5'd0, 2);
    drainFrame(0, 2, 1'b0, cyc);
    checkOutput("shortEndValid", 32'(out_valid), 32'd0);
    checkOutput("shortQueueEmpty", 32'(expQ.size()), 32'd0);

`ifdef RESULT_CHECKSUM_EN
    $display("[TB] checksum");
    for (int i = 0; i < 6; i++) wdata[i] = 16'(i + 1);
    applyStimulus(5'd4, 6);
    drainFrame(1, 6, 1'b0, cyc);
    checkOutput("chkSum21", 32'(chk_sum), 32'd21);
    wdata[0] = 16'hFFFF; wdata[1] = 16'h0002;
    applyStimulus(5'd0, 2);
    drainFrame(0, 2, 1'b0, cyc);
    checkOutput("chkSumWrap", 32'(chk_sum), 32'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
